// File: rtl/lcd_bus_pkg.sv
// Shared types, LCD command constants and helpers for the LCD1602 bus arbiter.
// Optional build macro used elsewhere in the slice: LCD_ARB_ROUND_ROBIN_EN.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Return-home ignores bit 0, so 8'h03 needs the long wait as well.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_bus_arbiter_if.sv
// Requester handshakes and LCD pin group for the LCD1602 bus arbiter.
interface lcd1602_bus_arbiter_if;

  logic       a_valid;
  logic       a_rs;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic       b_rs;
  logic [7:0] b_data;
  logic       b_ready;
  logic       busy;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data;

  modport master (
    output a_valid, a_rs, a_data, b_valid, b_rs, b_data,
    input  a_ready, b_ready, busy, rs, rw, enable, data
  );

  modport slave (
    input  a_valid, a_rs, a_data, b_valid, b_rs, b_data,
    output a_ready, b_ready, busy, rs, rw, enable, data
  );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-requester grant logic. LCD_ARB_ROUND_ROBIN_EN selects round-robin with a
// pointer register; otherwise A has fixed priority and no pointer exists.
module lcd_rr_arbiter
  import lcd_bus_pkg::*;
(
`ifdef LCD_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic idle,
`endif
  input  logic a_valid,
  input  logic b_valid,
  output logic grant_a,
  output logic grant_b
);

`ifdef LCD_ARB_ROUND_ROBIN_EN
  logic ptr_b;

  always_comb begin
    grant_a = a_valid & (~b_valid | ~ptr_b);
    grant_b = b_valid & (~a_valid | ptr_b);
  end

  // A grant in IDLE is always an accept, so the pointer moves only then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr_b <= 1'b0;
    else if (idle & grant_a)
      ptr_b <= 1'b1;
    else if (idle & grant_b)
      ptr_b <= 1'b0;
  end
`else
  assign grant_a = a_valid;
  assign grant_b = b_valid & ~a_valid;
`endif

endmodule

// File: rtl/lcd1602_bus_arbiter.sv
// LCD1602 bus arbiter: grants one byte transfer and sequences setup, enable
// pulse, hold and execution wait. Build option: LCD_ARB_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | waiting for a request; ready follows grant
// SETUP | rs/data stable before enable rises
// PULSE | enable high
// HOLD  | rs/data held after enable falls
// WAIT  | LCD execution time (short or clear/home)
module lcd1602_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int SETUP_CYCLES    = 3,
  parameter int EN_HIGH_CYCLES  = 25,
  parameter int HOLD_CYCLES     = 3,
  parameter int WAIT_CMD_CYCLES = 2000,
  parameter int WAIT_CLR_CYCLES = 82000
) (
  input logic            clk,
  input logic            reset,
  lcd1602_bus_arbiter_if.slave bus
);

  localparam int MAX_P = max_int(max_int(max_int(SETUP_CYCLES, EN_HIGH_CYCLES),
                                         max_int(HOLD_CYCLES, WAIT_CMD_CYCLES)),
                                 WAIT_CLR_CYCLES);
  localparam int CW = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(WAIT_CMD_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(WAIT_CLR_CYCLES - 1);

  lcd_state_t    state;
  logic [CW-1:0] cnt;
  logic          long_wait;
  logic          busy_q;
  logic          enable_q;
  logic          rs_q;
  logic [7:0]    data_q;

  logic          idle;
  logic          grant_a;
  logic          grant_b;
  logic          accept;
  logic          sel_rs;
  logic [7:0]    sel_data;

  assign idle = (state == ST_IDLE);

  lcd_rr_arbiter u_arb (
`ifdef LCD_ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .reset   (reset),
    .idle    (idle),
`endif
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign bus.a_ready = idle & grant_a;
  assign bus.b_ready = idle & grant_b;
  assign accept      = idle & (grant_a | grant_b);
  assign sel_rs      = grant_a ? bus.a_rs   : bus.b_rs;
  assign sel_data    = grant_a ? bus.a_data : bus.b_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      long_wait <= 1'b0;
      busy_q    <= 1'b0;
      enable_q  <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rs_q      <= sel_rs;
            data_q    <= sel_data;
            long_wait <= is_slow_cmd(sel_rs, sel_data);
            cnt       <= SETUP_LD;
            busy_q    <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            enable_q <= 1'b1;
            cnt      <= EN_LD;
            state    <= ST_PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            enable_q <= 1'b0;
            cnt      <= HOLD_LD;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= long_wait ? CLR_LD : CMD_LD;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          busy_q   <= 1'b0;
          enable_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.enable = enable_q;
  assign bus.rs     = rs_q;
  assign bus.data   = data_q;
  assign bus.rw     = 1'b0;

endmodule

// File: tb/tb_lcd1602_bus_arbiter.sv
// Directed self-checking bench for lcd1602_bus_arbiter with short timing
// parameters; contention expectations follow LCD_ARB_ROUND_ROBIN_EN.
module tb_lcd1602_bus_arbiter;

  localparam int S    = 2;
  localparam int E    = 4;
  localparam int H    = 2;
  localparam int WCMD = 10;
  localparam int WCLR = 40;
  localparam int XFER     = S + E + H + WCMD;
  localparam int XFER_CLR = S + E + H + WCLR;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  lcd1602_bus_arbiter_if bus ();

  lcd1602_bus_arbiter #(
    .SETUP_CYCLES    (S),
    .EN_HIGH_CYCLES  (E),
    .HOLD_CYCLES     (H),
    .WAIT_CMD_CYCLES (WCMD),
    .WAIT_CLR_CYCLES (WCLR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, " idle"}, bus.busy, 1'b0);
  endtask

  // Called at posedge+1 with the FSM idle; returns at posedge+1 with busy low.
  task automatic xfer(input bit use_b, input logic rs_v, input logic [7:0] d,
                      input int exp_busy, input string tag);
    int n        = 0;
    int busy_n   = 1;
    int en_first = -1;
    int en_n     = 0;
    int rw_bad   = 0;
    if (use_b) begin
      bus.b_valid = 1'b1; bus.b_rs = rs_v; bus.b_data = d;
    end else begin
      bus.a_valid = 1'b1; bus.a_rs = rs_v; bus.a_data = d;
    end
    #1;
    chk({tag, " ready"}, use_b ? bus.b_ready : bus.a_ready, 1'b1);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk({tag, " data"}, bus.data, d);
    chk({tag, " rs"}, bus.rs, rs_v);
    while (bus.busy === 1'b1 && n < 300) begin
      tick();
      n++;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.enable === 1'b1) begin
        en_n++;
        if (en_first < 0) en_first = n;
      end
      if (bus.rw !== 1'b0) rw_bad++;
    end
    chk({tag, " busy_len"}, busy_n, exp_busy);
    chk({tag, " en_start"}, en_first, S);
    chk({tag, " en_len"}, en_n, E);
    chk({tag, " rw"}, rw_bad, 0);
  endtask

  initial begin
    logic [3:0] exp_b;
    int r1, r2, acc2, n, bad;
    logic prev_en;

    reset = 1'b1;
    bus.a_valid = 1'b0; bus.a_rs = 1'b0; bus.a_data = 8'h00;
    bus.b_valid = 1'b0; bus.b_rs = 1'b0; bus.b_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("rst busy", bus.busy, 1'b0);
    chk("rst enable", bus.enable, 1'b0);
    chk("rst rs", bus.rs, 1'b0);
    chk("rst data", bus.data, 8'h00);
    chk("rst rw", bus.rw, 1'b0);
    chk("rst a_ready", bus.a_ready, 1'b0);
    tick();

    xfer(1'b0, 1'b1, 8'h41, XFER, "single");
    xfer(1'b1, 1'b0, 8'h01, XFER_CLR, "clear01");
    xfer(1'b1, 1'b0, 8'h38, XFER, "cmd38");
    xfer(1'b1, 1'b0, 8'h03, XFER_CLR, "home03");
    xfer(1'b1, 1'b0, 8'h04, XFER, "cmd04");
    xfer(1'b1, 1'b1, 8'h01, XFER, "data01");

    // Last served was B, so round-robin starts from A.
`ifdef LCD_ARB_ROUND_ROBIN_EN
    exp_b = 4'b1010;
`else
    exp_b = 4'b0000;
`endif
    bus.a_valid = 1'b1; bus.a_rs = 1'b1; bus.a_data = 8'h41;
    bus.b_valid = 1'b1; bus.b_rs = 1'b1; bus.b_data = 8'h42;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d a_ready", i), bus.a_ready, !exp_b[i]);
      chk($sformatf("cont%0d b_ready", i), bus.b_ready, exp_b[i]);
      tick();
      chk($sformatf("cont%0d data", i), bus.data, exp_b[i] ? 8'h42 : 8'h41);
      wait_idle($sformatf("cont%0d", i));
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();

    // Back-to-back: one idle cycle between transfers.
    bus.a_valid = 1'b1; bus.a_rs = 1'b1; bus.a_data = 8'h48;
    #1;
    chk("b2b ready", bus.a_ready, 1'b1);
    tick();
    chk("b2b data1", bus.data, 8'h48);
    bus.a_data = 8'h4F;
    r1 = -1; r2 = -1; acc2 = -1; prev_en = 1'b0;
    for (n = 1; n <= 24; n++) begin
      tick();
      if (bus.enable === 1'b1 && prev_en === 1'b0) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev_en = bus.enable;
      if (acc2 < 0 && bus.data === 8'h4F) acc2 = n;
      if (n == XFER) chk("b2b busy_gap", bus.busy, 1'b0);
    end
    bus.a_valid = 1'b0;
    chk("b2b accept2", acc2, XFER + 1);
    chk("b2b rise1", r1, S);
    chk("b2b rise_gap", r2 - r1, XFER + 1);
    wait_idle("b2b");
    tick();

    // Reset in the middle of the enable pulse.
    bus.a_valid = 1'b1; bus.a_rs = 1'b1; bus.a_data = 8'h55;
    tick();
    bus.a_valid = 1'b0;
    n = 0;
    while (bus.enable !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("midrst pulse", bus.enable, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst enable", bus.enable, 1'b0);
    chk("midrst rs", bus.rs, 1'b0);
    chk("midrst data", bus.data, 8'h00);
    chk("midrst busy", bus.busy, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    tick();
    chk("postrst busy", bus.busy, 1'b0);
    chk("postrst enable", bus.enable, 1'b0);
    bus.a_valid = 1'b1; bus.a_rs = 1'b1; bus.a_data = 8'h5A;
    bus.b_valid = 1'b1; bus.b_rs = 1'b0; bus.b_data = 8'h66;
    #1;
    chk("postrst a_ready", bus.a_ready, 1'b1);
    chk("postrst b_ready", bus.b_ready, 1'b0);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    chk("postrst data", bus.data, 8'h5A);
    wait_idle("postrst");

    // Idle stability with no requesters.
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.busy !== 1'b0 || bus.enable !== 1'b0 || bus.data !== 8'h5A ||
          bus.rs !== 1'b1 || bus.rw !== 1'b0)
        bad++;
    end
    chk("idle stable", bad, 0);
    chk("idle data", bus.data, 8'h5A);
    chk("idle rs", bus.rs, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
